serial_rx_frame: RTL and testbench

Asynchronous serial frame receiver: samples a 1-bit line (idle high), detects a start bit, shifts in DATA_W data bits LSB-first, checks the stop bit, and presents the received word with a one-cycle valid strobe. It sits directly downstream of the single-bit stimulus or line source and feeds word-wide consumers such as counters, comparators and displays.

---
 rtl/serial_rx_frame_pkg.sv | 17 +
 rtl/serial_rx_frame_bit_sync.sv | 30 +++
 rtl/serial_rx_frame.sv | 138 +++++++++++++
 tb/tb_serial_rx_frame.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_frame_pkg.sv
// serial_rx_frame_pkg
// Shared definitions for the serial line receiver (and a future transmitter):
// FSM state encodings and the idle level of the serial line.
package serial_rx_frame_pkg;

   // Receiver / transmitter frame states; encodings are fixed so both sides agree.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   // Level of an idle serial line; also the reset value of the line synchronizer.
   localparam logic LINE_IDLE = 1'b1;

endpackage : serial_rx_frame_pkg

// File: rtl/serial_rx_frame_bit_sync.sv
// bit_sync
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk  in   destination clock
//   rst  in   synchronous active-high reset; both flops load RESET_VAL
//   d    in   asynchronous input
//   q    out  synchronized output (2-cycle latency)
module bit_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : bit_sync

// File: rtl/serial_rx_frame.sv
// serial_rx_frame
// Asynchronous serial frame receiver: start bit, DATA_W data bits LSB-first,
// one stop bit. The line is oversampled at CLKS_PER_BIT clocks per bit and
// every bit is sampled near its centre.
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   rx         in   serial line (asynchronous, idle high)
//   data       out  last correctly framed word, held until the next one
//   valid      out  one-cycle pulse when data is updated
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   busy       out  high whenever the FSM is not idle
module serial_rx_frame
   import serial_rx_frame_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic [DATA_W-1:0] data,
   output logic              valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_W + 1);

   // Last count value of the half-bit and full-bit intervals.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

   logic              rx_s;
   rx_state_t         state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  bit_idx;
   logic [DATA_W-1:0] shift;

   bit_sync #(
      .RESET_VAL (LINE_IDLE)
   ) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   // Frame FSM with bit timing counter, data shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         // Status strobes are single-cycle unless re-asserted below.
         valid     <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_s == 1'b0) begin
                  state <= ST_START;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end else begin
                  busy  <= 1'b0;
               end
            end
            ST_START: begin
               // Re-check the line half a bit in: a high line means the low
               // level was only a glitch.
               if (cnt == HALF_LAST) begin
                  if (rx_s == 1'b0) begin
                     state   <= ST_DATA;
                     cnt     <= '0;
                     bit_idx <= '0;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DATA: begin
               // From the start-bit centre, one full bit period lands on the
               // centre of each data bit.
               if (cnt == BIT_LAST) begin
                  for (int i = 0; i < DATA_W; i++) begin
                     if (bit_idx == IDX_W'(i)) begin
                        shift[i] <= rx_s;
                     end
                  end
                  cnt     <= '0;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == IDX_LAST) begin
                     state <= ST_STOP;
                  end else begin
                     state <= ST_DATA;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_STOP: begin
               if (cnt == BIT_LAST) begin
                  if (rx_s == 1'b1) begin
                     data  <= shift;
                     valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  // Return to IDLE immediately so a back-to-back start bit
                  // is seen on the very next cycle.
                  state <= ST_IDLE;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule : serial_rx_frame

// File: tb/tb_serial_rx_frame.sv
// tb_serial_rx_frame
// Directed self-checking bench. dut_a runs with CLKS_PER_BIT=4, dut_b with the
// default CLKS_PER_BIT=16; both use DATA_W=8. Bits are driven just after a
// rising edge, so the first low edge of a frame follows the drive point by one
// edge; a result at edge E therefore appears at the negedge of cycle start+E+1.
module tb_serial_rx_frame;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic [7:0] data_a, data_b;
   logic       valid_a, valid_b, frame_err_a, frame_err_b, busy_a, busy_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Monitor records
   logic [7:0] a_vq[$];
   int         a_cq[$];
   int         a_eq[$];
   int         a_busy_cnt = 0;
   int         a_both = 0;
   logic [7:0] b_vq[$];
   int         b_cq[$];
   int         b_eq[$];

   serial_rx_frame #(.CLKS_PER_BIT(4), .DATA_W(8)) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .data(data_a),
      .valid(valid_a), .frame_err(frame_err_a), .busy(busy_a)
   );

   serial_rx_frame dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .data(data_b),
      .valid(valid_b), .frame_err(frame_err_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_a) begin
         a_vq.push_back(data_a);
         a_cq.push_back(cyc);
      end
      if (frame_err_a) a_eq.push_back(cyc);
      if (busy_a) a_busy_cnt++;
      if (valid_a && frame_err_a) a_both++;
      if (valid_b) begin
         b_vq.push_back(data_b);
         b_cq.push_back(cyc);
      end
      if (frame_err_b) b_eq.push_back(cyc);
   end

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      a_vq.delete(); a_cq.delete(); a_eq.delete();
      b_vq.delete(); b_cq.delete(); b_eq.delete();
      a_busy_cnt = 0;
      a_both = 0;
   endtask

   // Hold a level on the line for n clocks; called and returns at #1 after posedge.
   task automatic drive_a(input logic v, input int n);
      rx_a = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_b(input logic v, input int n);
      rx_b = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [7:0] d, input logic stop);
      drive_a(1'b0, 4);
      for (int i = 0; i < 8; i++) drive_a(d[i], 4);
      drive_a(stop, 4);
   endtask

   task automatic send_b(input logic [7:0] d, input logic stop);
      drive_b(1'b0, 16);
      for (int i = 0; i < 8; i++) drive_b(d[i], 16);
      drive_b(stop, 16);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({data_a, valid_a, frame_err_a, busy_a} !== 11'h000) begin
         errors++;
         $display("FAIL reset_a: got data=%h v=%b e=%b b=%b want all 0", data_a, valid_a, frame_err_a, busy_a);
      end
      checks++;
      if ({data_b, valid_b, frame_err_b, busy_b} !== 11'h000) begin
         errors++;
         $display("FAIL reset_b: got data=%h v=%b e=%b b=%b want all 0", data_b, valid_b, frame_err_b, busy_b);
      end
      rst = 1'b0;
      drive_a(1'b1, 4);
   endtask

   task automatic test_good_frame();
      int start;
      clear_mon();
      start = cyc;
      send_a(8'hA5, 1'b1);
      drive_a(1'b1, 8);
      checks++;
      if (a_vq.size() != 1) begin
         errors++;
         $display("FAIL good_valid_count: got %0d want 1", a_vq.size());
      end else begin
         checks++;
         if (a_vq[0] !== 8'hA5) begin
            errors++;
            $display("FAIL good_data: got %h want a5", a_vq[0]);
         end
         checks++;
         if (a_cq[0] - start != 41) begin
            errors++;
            $display("FAIL good_timing: got edge %0d want 40", a_cq[0] - start - 1);
         end
      end
      checks++;
      if (a_eq.size() != 0) begin
         errors++;
         $display("FAIL good_no_err: got %0d frame_err pulses want 0", a_eq.size());
      end
      checks++;
      if (busy_a !== 1'b0) begin
         errors++;
         $display("FAIL good_busy_after: got %b want 0", busy_a);
      end
      // busy from after edge 2 to after edge 40: 38 cycles
      checks++;
      if (a_busy_cnt != 38) begin
         errors++;
         $display("FAIL good_busy_len: got %0d want 38", a_busy_cnt);
      end
   endtask

   task automatic test_stop_err();
      int start;
      rst = 1'b1;
      align();
      rst = 1'b0;
      clear_mon();
      start = cyc;
      send_a(8'hA5, 1'b0);
      drive_a(1'b1, 10);
      checks++;
      if (a_eq.size() != 1) begin
         errors++;
         $display("FAIL err_count: got %0d want 1", a_eq.size());
      end else begin
         checks++;
         if (a_eq[0] - start != 41) begin
            errors++;
            $display("FAIL err_timing: got edge %0d want 40", a_eq[0] - start - 1);
         end
      end
      checks++;
      if (a_vq.size() != 0) begin
         errors++;
         $display("FAIL err_no_valid: got %0d valid pulses want 0", a_vq.size());
      end
      checks++;
      if (data_a !== 8'h00) begin
         errors++;
         $display("FAIL err_data_hold_reset: got %h want 00", data_a);
      end
      // A bad frame after a good one keeps the good word.
      send_a(8'h3C, 1'b1);
      drive_a(1'b1, 8);
      send_a(8'h5A, 1'b0);
      drive_a(1'b1, 10);
      checks++;
      if (data_a !== 8'h3C) begin
         errors++;
         $display("FAIL err_data_hold: got %h want 3c", data_a);
      end
      checks++;
      if (a_eq.size() != 2 || a_vq.size() != 1) begin
         errors++;
         $display("FAIL err_pulses: got err=%0d valid=%0d want 2 and 1", a_eq.size(), a_vq.size());
      end
   endtask

   task automatic test_glitch();
      clear_mon();
      drive_a(1'b0, 1);
      drive_a(1'b1, 12);
      checks++;
      if (a_busy_cnt != 2) begin
         errors++;
         $display("FAIL glitch_busy: got %0d busy cycles want 2", a_busy_cnt);
      end
      checks++;
      if (a_vq.size() != 0 || a_eq.size() != 0) begin
         errors++;
         $display("FAIL glitch_pulses: got valid=%0d err=%0d want 0 and 0", a_vq.size(), a_eq.size());
      end
   endtask

   task automatic test_back_to_back();
      int start;
      clear_mon();
      start = cyc;
      send_a(8'h00, 1'b1);
      send_a(8'hFF, 1'b1);
      drive_a(1'b1, 8);
      checks++;
      if (a_vq.size() != 2) begin
         errors++;
         $display("FAIL b2b_count: got %0d want 2", a_vq.size());
      end else begin
         checks++;
         if (a_vq[0] !== 8'h00 || a_vq[1] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_data: got %h,%h want 00,ff", a_vq[0], a_vq[1]);
         end
         // The second frame starts one frame time (10 bits) after the first.
         checks++;
         if (a_cq[1] - a_cq[0] != 40 || a_cq[0] - start != 41) begin
            errors++;
            $display("FAIL b2b_timing: got first %0d gap %0d want 41 and 40", a_cq[0] - start, a_cq[1] - a_cq[0]);
         end
      end
      checks++;
      if (a_eq.size() != 0 || a_both != 0) begin
         errors++;
         $display("FAIL b2b_err: got err=%0d both=%0d want 0 and 0", a_eq.size(), a_both);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d = 8'h3C;
      clear_mon();
      drive_a(1'b0, 4);
      for (int i = 0; i < 4; i++) drive_a(d[i], 4);
      rx_a = d[4];
      rst = 1'b1;
      align();
      rst = 1'b0;
      checks++;
      if ({data_a, valid_a, frame_err_a, busy_a} !== 11'h000) begin
         errors++;
         $display("FAIL midreset_state: got data=%h v=%b e=%b b=%b want all 0", data_a, valid_a, frame_err_a, busy_a);
      end
      drive_a(1'b1, 60);
      checks++;
      if (a_vq.size() != 0 || a_eq.size() != 0) begin
         errors++;
         $display("FAIL midreset_silent: got valid=%0d err=%0d want 0 and 0", a_vq.size(), a_eq.size());
      end
      send_a(8'h3C, 1'b1);
      drive_a(1'b1, 8);
      checks++;
      if (a_vq.size() != 1 || data_a !== 8'h3C) begin
         errors++;
         $display("FAIL midreset_next: got count=%0d data=%h want 1 and 3c", a_vq.size(), data_a);
      end
   endtask

   task automatic test_default_timing();
      int start;
      clear_mon();
      start = cyc;
      send_b(8'h81, 1'b1);
      drive_b(1'b1, 20);
      checks++;
      if (b_vq.size() != 1) begin
         errors++;
         $display("FAIL dflt_count: got %0d want 1", b_vq.size());
      end else begin
         checks++;
         if (b_vq[0] !== 8'h81) begin
            errors++;
            $display("FAIL dflt_data: got %h want 81", b_vq[0]);
         end
         checks++;
         if (b_cq[0] - start != 155) begin
            errors++;
            $display("FAIL dflt_timing: got edge %0d want 154", b_cq[0] - start - 1);
         end
      end
   endtask

   task automatic test_random_stream();
      logic [7:0] exp_q[$];
      logic [7:0] d;
      clear_mon();
      for (int n = 0; n < 100; n++) begin
         d = 8'($urandom_range(0, 255));
         exp_q.push_back(d);
         send_b(d, 1'b1);
      end
      drive_b(1'b1, 40);
      checks++;
      if (b_vq.size() != 100 || b_eq.size() != 0) begin
         errors++;
         $display("FAIL rand_count: got valid=%0d err=%0d want 100 and 0", b_vq.size(), b_eq.size());
      end else begin
         for (int n = 0; n < 100; n++) begin
            checks++;
            if (b_vq[n] !== exp_q[n]) begin
               errors++;
               $display("FAIL rand_data[%0d]: got %h want %h", n, b_vq[n], exp_q[n]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_stop_err();
      test_glitch();
      test_back_to_back();
      test_reset_mid();
      test_default_timing();
      test_random_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_serial_rx_frame
